// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one registered memory port between an instruction-fetch and a data requester
//   clk, rst_n          : clock, asynchronous active-low reset
//   if_req/if_addr      : fetch request, answered by a one-cycle if_ready with if_rdata
//   dm_req/dm_we/dm_*   : load/store request, answered by a one-cycle dm_ready (dm_rdata on loads)
//   mem_addr/we/wdata   : registered shared memory port; mem_rdata returns combinationally
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ready,
    output logic [31:0] dm_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACC_IF, ACC_DM} state_t;
    state_t      state_q, state_d;
    logic [2:0]  starve_q, starve_d;
    logic        if_elig, dm_elig, starve_full;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic        mem_we_q, mem_we_d, if_ready_q, if_ready_d, dm_ready_q, dm_ready_d;
    always_comb begin
        // the requester being served this cycle is still holding its old request, so it sits out one arbitration
        if_elig     = if_req && state_q != ACC_IF;
        dm_elig     = dm_req && state_q != ACC_DM;
        starve_full = starve_q == 3'(STARVE_LIMIT);
        state_d     = (dm_elig && !(starve_full && if_elig)) ? ACC_DM : if_elig ? ACC_IF : IDLE;
        starve_d    = (!if_req || state_d == ACC_IF) ? 3'd0 :
                      (state_d == ACC_DM && !starve_full) ? starve_q + 3'd1 : starve_q;
        mem_addr_d  = state_d == ACC_DM ? dm_addr : state_d == ACC_IF ? if_addr : mem_addr_q;
        mem_we_d    = state_d == ACC_DM && dm_we;
        mem_wdata_d = state_d == ACC_DM ? dm_wdata : mem_wdata_q;
        if_ready_d  = state_q == ACC_IF;
        if_rdata_d  = state_q == ACC_IF ? mem_rdata : if_rdata_q;
        dm_ready_d  = state_q == ACC_DM;
        // a store leaves the last load result visible
        dm_rdata_d  = (state_q == ACC_DM && !mem_we_q) ? mem_rdata : dm_rdata_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            starve_q    <= 3'd0;
            mem_addr_q  <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 32'd0;
            if_ready_q  <= 1'b0;
            if_rdata_q  <= 32'd0;
            dm_ready_q  <= 1'b0;
            dm_rdata_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            if_rdata_q  <= if_rdata_d;
            dm_ready_q  <= dm_ready_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign dm_ready  = dm_ready_q;
    assign dm_rdata  = dm_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a word-memory reference model
module tb_mem_port_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
    logic        if_ready, dm_ready, mem_we;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    int          pass_cnt = 0, total_cnt = 0;
    logic [31:0] mem [256];
    logic [255:0] vld;
    logic        mem_clr = 1'b0, pl_en = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_dat = '0;
    logic [31:0] rm [256];
    int          if_done = 0, dm_done = 0, if_seen = 0, dm_seen = 0, overlap = 0;
    logic        if_fin = 1'b0, dm_fin = 1'b0;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(logic [7:0] i);
        return {8'hA5, i, ~i, i ^ 8'h3C};
    endfunction

    assign mem_rdata = vld[mem_addr[9:2]] ? mem[mem_addr[9:2]] : init_word(mem_addr[9:2]);

    always @(posedge clk) begin
        if (mem_clr) vld <= '0;
        else begin
            if (pl_en) begin
                mem[pl_idx] <= pl_dat;
                vld[pl_idx] <= 1'b1;
            end
            if (mem_we) begin
                mem[mem_addr[9:2]] <= mem_wdata;
                vld[mem_addr[9:2]] <= 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_clr = 1'b1;
        step();
        step();
        mem_clr = 1'b0;
        total_cnt++;
        if ({if_ready, dm_ready, mem_we} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {if_ready, dm_ready, mem_we});
        else pass_cnt++;
        total_cnt++;
        if ({mem_addr, mem_wdata} !== 64'd0) $display("FAIL reset_port: got %h want 0", {mem_addr, mem_wdata});
        else pass_cnt++;
        total_cnt++;
        if ({if_rdata, dm_rdata} !== 64'd0) $display("FAIL reset_rdata: got %h want 0", {if_rdata, dm_rdata});
        else pass_cnt++;
        rst_n = 1'b1;
        step();
        total_cnt++;
        if (mem_we !== 1'b0 || if_ready !== 1'b0 || dm_ready !== 1'b0) $display("FAIL idle_after_reset: got we=%b ir=%b dr=%b want 0", mem_we, if_ready, dm_ready);
        else pass_cnt++;
    endtask

    task automatic test_fetch();
        pl_en = 1'b1;
        pl_idx = 8'd0;
        pl_dat = 32'h2408_0005;
        step();
        pl_en = 1'b0;
        if_addr = 32'h0040_0000;
        if_req = 1'b1;
        step();
        total_cnt++;
        if (mem_addr !== 32'h0040_0000) $display("FAIL fetch_addr: got %h want 00400000", mem_addr);
        else pass_cnt++;
        total_cnt++;
        if (mem_we !== 1'b0 || if_ready !== 1'b0) $display("FAIL fetch_access: got we=%b ready=%b want 0 0", mem_we, if_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if (if_ready !== 1'b1) $display("FAIL fetch_ready: got %b want 1", if_ready);
        else pass_cnt++;
        total_cnt++;
        if (if_rdata !== 32'h2408_0005) $display("FAIL fetch_rdata: got %h want 24080005", if_rdata);
        else pass_cnt++;
        if_req = 1'b0;
        step();
        total_cnt++;
        if (if_ready !== 1'b0 || if_rdata !== 32'h2408_0005) $display("FAIL fetch_pulse: got ready=%b rdata=%h want 0 24080005", if_ready, if_rdata);
        else pass_cnt++;
    endtask

    task automatic test_store_load();
        dm_we = 1'b1;
        dm_addr = 32'h7FFF_EFFC;
        dm_wdata = 32'hDEAD_BEEF;
        dm_req = 1'b1;
        step();
        total_cnt++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h7FFF_EFFC, 32'hDEAD_BEEF}) $display("FAIL store_port: got we=%b addr=%h wdata=%h want 1 7fffeffc deadbeef", mem_we, mem_addr, mem_wdata);
        else pass_cnt++;
        total_cnt++;
        if (dm_ready !== 1'b0) $display("FAIL store_early_ready: got %b want 0", dm_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if (dm_ready !== 1'b1 || mem_we !== 1'b0) $display("FAIL store_done: got ready=%b we=%b want 1 0", dm_ready, mem_we);
        else pass_cnt++;
        total_cnt++;
        if (dm_rdata !== 32'd0) $display("FAIL store_rdata_kept: got %h want 0", dm_rdata);
        else pass_cnt++;
        dm_we = 1'b0;
        step();
        total_cnt++;
        if (mem_we !== 1'b0 || dm_ready !== 1'b0 || mem_addr !== 32'h7FFF_EFFC) $display("FAIL load_access: got we=%b ready=%b addr=%h want 0 0 7fffeffc", mem_we, dm_ready, mem_addr);
        else pass_cnt++;
        step();
        total_cnt++;
        if (dm_ready !== 1'b1 || dm_rdata !== 32'hDEAD_BEEF) $display("FAIL load_data: got ready=%b rdata=%h want 1 deadbeef", dm_ready, dm_rdata);
        else pass_cnt++;
        dm_req = 1'b0;
        step();
        total_cnt++;
        if (dm_ready !== 1'b0) $display("FAIL load_pulse: got %b want 0", dm_ready);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        if_addr = 32'h0040_0200;
        dm_addr = 32'h0000_0040;
        dm_we = 1'b0;
        if_req = 1'b1;
        dm_req = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            total_cnt++;
            if (mem_addr !== ((k % 2 == 1) ? dm_addr : if_addr)) $display("FAIL alt_grant k=%0d: got %h want %h", k, mem_addr, (k % 2 == 1) ? dm_addr : if_addr);
            else pass_cnt++;
            total_cnt++;
            if (dm_ready !== (k >= 2 && k % 2 == 0)) $display("FAIL alt_dm_ready k=%0d: got %b want %b", k, dm_ready, (k >= 2 && k % 2 == 0));
            else pass_cnt++;
            total_cnt++;
            if (if_ready !== (k >= 3 && k % 2 == 1)) $display("FAIL alt_if_ready k=%0d: got %b want %b", k, if_ready, (k >= 3 && k % 2 == 1));
            else pass_cnt++;
            if (k == 4) begin
                total_cnt++;
                if (dm_rdata !== init_word(8'h10) || if_rdata !== init_word(8'h80)) $display("FAIL alt_data: got dm=%h if=%h want %h %h", dm_rdata, if_rdata, init_word(8'h10), init_word(8'h80));
                else pass_cnt++;
            end
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_mid_store();
        dm_we = 1'b1;
        dm_addr = 32'h0000_0080;
        dm_wdata = 32'h1234_5678;
        dm_req = 1'b1;
        step();
        total_cnt++;
        if (mem_we !== 1'b1) $display("FAIL rst_store_started: got %b want 1", mem_we);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({mem_we, dm_ready, if_ready, mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0) $display("FAIL rst_async_clear: got we=%b addr=%h wdata=%h ifd=%h dmd=%h want all 0", mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata);
        else pass_cnt++;
        step();
        total_cnt++;
        if (dm_ready !== 1'b0 || mem_we !== 1'b0) $display("FAIL rst_no_ready: got ready=%b we=%b want 0 0", dm_ready, mem_we);
        else pass_cnt++;
        total_cnt++;
        if ((vld[8'h20] ? mem[8'h20] : init_word(8'h20)) !== init_word(8'h20)) $display("FAIL rst_no_write: got %h want %h", mem[8'h20], init_word(8'h20));
        else pass_cnt++;
        rst_n = 1'b1;
        step();
        total_cnt++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h0000_0080) $display("FAIL rst_regrant: got we=%b addr=%h want 1 00000080", mem_we, mem_addr);
        else pass_cnt++;
        step();
        total_cnt++;
        if (dm_ready !== 1'b1) $display("FAIL rst_complete: got %b want 1", dm_ready);
        else pass_cnt++;
        dm_req = 1'b0;
        step();
        total_cnt++;
        if ((vld[8'h20] ? mem[8'h20] : init_word(8'h20)) !== 32'h1234_5678) $display("FAIL rst_written: got %h want 12345678", mem[8'h20]);
        else pass_cnt++;
    endtask

    task automatic test_random();
        mem_clr = 1'b1;
        step();
        mem_clr = 1'b0;
        for (int i = 0; i < 256; i++) rm[i] = init_word(8'(i));
        fork
            begin
                logic [31:0] last_load, r, wd;
                logic [6:0]  ix;
                logic        got, we;
                last_load = 32'd0;
                for (int n = 0; n < 2500; n++) begin
                    if (!dm_req) repeat ($urandom_range(0, 3)) step();
                    r = $urandom();
                    ix = 7'($urandom_range(0, 127));
                    we = 1'($urandom_range(0, 1));
                    wd = $urandom();
                    dm_we = we;
                    dm_addr = {r[31:10], 1'b0, ix, 2'b00};
                    dm_wdata = wd;
                    dm_req = 1'b1;
                    got = 1'b0;
                    for (int c = 0; c < 20 && !got; c++) begin
                        step();
                        got = dm_ready;
                    end
                    total_cnt++;
                    if (!got) $display("FAIL dm_timeout n=%0d: got no ready want ready within 20 cycles", n);
                    else pass_cnt++;
                    if (got) begin
                        if (we) rm[{1'b0, ix}] = wd;
                        else last_load = rm[{1'b0, ix}];
                        total_cnt++;
                        if (dm_rdata !== last_load) $display("FAIL dm_data n=%0d we=%b: got %h want %h", n, we, dm_rdata, last_load);
                        else pass_cnt++;
                        dm_done++;
                    end
                    if ($urandom_range(0, 1) == 0) dm_req = 1'b0;
                end
                dm_req = 1'b0;
                dm_fin = 1'b1;
            end
            begin
                logic [31:0] r;
                logic [6:0]  ix;
                logic        got;
                for (int n = 0; n < 2500; n++) begin
                    if (!if_req) repeat ($urandom_range(0, 3)) step();
                    r = $urandom();
                    ix = 7'($urandom_range(0, 127));
                    if_addr = {r[31:10], 1'b1, ix, 2'b00};
                    if_req = 1'b1;
                    got = 1'b0;
                    for (int c = 0; c < 20 && !got; c++) begin
                        step();
                        got = if_ready;
                    end
                    total_cnt++;
                    if (!got) $display("FAIL if_timeout n=%0d: got no ready want ready within 20 cycles", n);
                    else pass_cnt++;
                    if (got) begin
                        total_cnt++;
                        if (if_rdata !== rm[{1'b1, ix}]) $display("FAIL if_data n=%0d: got %h want %h", n, if_rdata, rm[{1'b1, ix}]);
                        else pass_cnt++;
                        if_done++;
                    end
                    if ($urandom_range(0, 1) == 0) if_req = 1'b0;
                end
                if_req = 1'b0;
                if_fin = 1'b1;
            end
            begin
                while (!(if_fin && dm_fin)) begin
                    step();
                    if (if_ready) if_seen++;
                    if (dm_ready) dm_seen++;
                    if (if_ready && dm_ready) overlap++;
                end
            end
        join
        repeat (4) begin
            step();
            if (if_ready) if_seen++;
            if (dm_ready) dm_seen++;
            if (if_ready && dm_ready) overlap++;
        end
        total_cnt++;
        if (if_seen !== if_done) $display("FAIL if_ready_count: got %0d want %0d", if_seen, if_done);
        else pass_cnt++;
        total_cnt++;
        if (dm_seen !== dm_done) $display("FAIL dm_ready_count: got %0d want %0d", dm_seen, dm_done);
        else pass_cnt++;
        total_cnt++;
        if (overlap !== 0) $display("FAIL ready_overlap: got %0d want 0", overlap);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_load();
        test_back_to_back();
        test_reset_mid_store();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
